adc_level_classifier: RTL and testbench

//  Consumes the six 12-bit channel registers (ch0..ch5) from the ADC controller. Scans them round-robin,

---
 rtl/adc_lvl_pkg.sv | 29 ++
 rtl/adc_lvl_hyst.sv | 58 +++++
 rtl/adc_level_classifier.sv | 244 ++++++++++++++++++++++++
 tb/tb_adc_level_classifier.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_lvl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_lvl_pkg
// Brief    : Shared types and constants for the ADC level classifier
//            (channel count, sample width, scan FSM encoding).
// Revision : 1.0 - initial release
// ============================================================================
package adc_lvl_pkg;

    localparam int NUM_CH   = 6;
    localparam int ADC_W    = 12;
    localparam int CH_IDX_W = 3;

    typedef logic [ADC_W-1:0]    adc_sample_t;
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILT  = 2'd1,
        S_CLASS = 2'd2
    } adc_lvl_state_t;

    // Round-robin successor of a channel index
    function automatic ch_idx_t next_ch(input ch_idx_t idx);
        return (idx == ch_idx_t'(NUM_CH - 1)) ? '0 : idx + ch_idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_lvl_hyst.sv
`default_nettype none
// ============================================================================
// Module   : adc_lvl_hyst
// Brief    : Combinational hysteresis decision. Given the committed level L
//            and the (filtered) sample v, decides whether v has moved far
//            enough past a bin edge to propose a new level, and which one.
//            Shared by all channels through the scan time-multiplex.
// Revision : 1.0 - initial release
// ============================================================================
module adc_lvl_hyst
    import adc_lvl_pkg::*;
#(
    parameter int LEVEL_BITS = 3,
    parameter int HYST       = 32
) (
    input  logic [LEVEL_BITS-1:0] lvl_i,
    input  logic [ADC_W-1:0]      v_i,
    output logic                  up_o,
    output logic                  down_o,
    output logic [LEVEL_BITS-1:0] new_o
);

    localparam int                    c_BIN     = (1 << ADC_W) >> LEVEL_BITS;
    localparam int                    c_CMP_W   = ADC_W + 2;
    localparam logic [LEVEL_BITS-1:0] c_MAX_LVL = '1;

    logic [c_CMP_W-1:0] w_v_ext;
    logic [c_CMP_W-1:0] w_up_thr;
    logic [c_CMP_W-1:0] w_down_thr;
    logic               w_can_up;
    logic               w_can_down;

    assign w_v_ext    = c_CMP_W'(v_i);
    assign w_can_up   = (lvl_i != c_MAX_LVL);
    assign w_can_down = (lvl_i != '0);

    // Thresholds are only formed where they are meaningful, so the top bin
    // never computes an upper edge and bin 0 never subtracts below zero
    always_comb begin
        w_up_thr   = '1;
        w_down_thr = '0;
        if (w_can_up) begin
            w_up_thr = c_CMP_W'((int'(lvl_i) + 1) * c_BIN + HYST);
        end
        if (w_can_down) begin
            w_down_thr = c_CMP_W'(int'(lvl_i) * c_BIN - HYST);
        end
    end

    // Crossing decision and proposed level (raw bin of v when crossed)
    always_comb begin
        up_o   = w_can_up   && (w_v_ext >= w_up_thr);
        down_o = w_can_down && (w_v_ext <  w_down_thr);
        new_o  = (up_o || down_o) ? v_i[ADC_W-1 -: LEVEL_BITS] : lvl_i;
    end

endmodule
`default_nettype wire

// File: rtl/adc_level_classifier.sv
`default_nettype none
// ============================================================================
// Module   : adc_level_classifier
// Brief    : Round-robin scanner over six 12-bit ADC channels. Each visit
//            optionally low-pass filters the channel, quantises it into a
//            LEVEL_BITS code with hysteresis, and commits a new level only
//            after it persists for STABLE_SCANS visits, pulsing changed[i].
// Config   : define ADC_LVL_FILTER_EN to enable the per-channel EMA filter
//            (alpha = 2**-FILT_SHIFT); otherwise the raw sample is used.
// Revision : 1.0 - initial release
// ============================================================================
module adc_level_classifier
    import adc_lvl_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int LEVEL_BITS   = 3,
    parameter int HYST         = 32,
    parameter int STABLE_SCANS = 3,
    parameter int FILT_SHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADC_W-1:0]      ch0,
    input  logic [ADC_W-1:0]      ch1,
    input  logic [ADC_W-1:0]      ch2,
    input  logic [ADC_W-1:0]      ch3,
    input  logic [ADC_W-1:0]      ch4,
    input  logic [ADC_W-1:0]      ch5,
    output logic [LEVEL_BITS-1:0] lvl0,
    output logic [LEVEL_BITS-1:0] lvl1,
    output logic [LEVEL_BITS-1:0] lvl2,
    output logic [LEVEL_BITS-1:0] lvl3,
    output logic [LEVEL_BITS-1:0] lvl4,
    output logic [LEVEL_BITS-1:0] lvl5,
    output logic [NUM_CH-1:0]     changed,
    output logic                  ready
);

    localparam int                  c_TICK_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                  c_CNT_W     = 4;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_STABLE    = c_CNT_W'(STABLE_SCANS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_TICK_W-1:0]   tick_cnt_q;
    adc_lvl_state_t        state_q;
    ch_idx_t               ch_idx_q;
    adc_sample_t           v_q;
    logic [NUM_CH-1:0]     primed_q;
    logic [LEVEL_BITS-1:0] lvl_q  [NUM_CH];
    logic [LEVEL_BITS-1:0] cand_q [NUM_CH];
    logic [c_CNT_W-1:0]    cnt_q  [NUM_CH];
    logic [NUM_CH-1:0]     changed_q;
    logic                  ready_q;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                  w_tick;
    adc_sample_t           w_sample;
    adc_sample_t           v_d;
    logic [LEVEL_BITS-1:0] w_raw_lvl;
    logic [LEVEL_BITS-1:0] w_cur_lvl;
    logic [LEVEL_BITS-1:0] w_cur_cand;
    logic [c_CNT_W-1:0]    w_cur_cnt;
    logic [LEVEL_BITS-1:0] w_new_lvl;
    logic                  w_up;
    logic                  w_down;
    logic [LEVEL_BITS-1:0] cand_d;
    logic [c_CNT_W-1:0]    cnt_d;
    logic                  w_commit;
    logic [NUM_CH-1:0]     primed_d;

    assign w_tick = (tick_cnt_q == c_TICK_LAST);

    // Free-running visit timer; one tick every SCAN_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (w_tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + c_TICK_W'(1);
        end
    end

    // Select the channel being visited; inputs are only looked at here
    always_comb begin
        case (ch_idx_q)
            3'd0:    w_sample = ch0;
            3'd1:    w_sample = ch1;
            3'd2:    w_sample = ch2;
            3'd3:    w_sample = ch3;
            3'd4:    w_sample = ch4;
            3'd5:    w_sample = ch5;
            default: w_sample = '0;
        endcase
    end

`ifdef ADC_LVL_FILTER_EN
    localparam int c_DIFF_W = ADC_W + 1;

    adc_sample_t                 filt_q [NUM_CH];
    logic signed [c_DIFF_W-1:0]  w_diff;
    logic signed [c_DIFF_W-1:0]  w_step;
    logic        [c_DIFF_W-1:0]  w_diff_mag;
    adc_sample_t                 w_filt_new;

    // EMA step; snaps to the sample once the residual is below one shift
    // quantum so the filter always settles exactly on a constant input
    always_comb begin
        w_diff     = $signed({1'b0, w_sample}) - $signed({1'b0, filt_q[ch_idx_q]});
        w_step     = w_diff >>> FILT_SHIFT;
        w_diff_mag = w_diff[c_DIFF_W-1] ? unsigned'(-w_diff) : unsigned'(w_diff);
        if (w_diff_mag < c_DIFF_W'(1 << FILT_SHIFT)) begin
            w_filt_new = w_sample;
        end else begin
            w_filt_new = ADC_W'($signed({1'b0, filt_q[ch_idx_q]}) + w_step);
        end
        v_d = primed_q[ch_idx_q] ? w_filt_new : w_sample;
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (FILT_SHIFT != 0);

    // Unfiltered build: the visit value is the raw sample
    always_comb begin
        v_d = w_sample;
    end
`endif

    assign w_raw_lvl  = v_q[ADC_W-1 -: LEVEL_BITS];
    assign w_cur_lvl  = lvl_q[ch_idx_q];
    assign w_cur_cand = cand_q[ch_idx_q];
    assign w_cur_cnt  = cnt_q[ch_idx_q];

    adc_lvl_hyst #(
        .LEVEL_BITS (LEVEL_BITS),
        .HYST       (HYST)
    ) u_hyst (
        .lvl_i  (w_cur_lvl),
        .v_i    (v_q),
        .up_o   (w_up),
        .down_o (w_down),
        .new_o  (w_new_lvl)
    );

    // Persistence: a proposed level must repeat on consecutive visits
    always_comb begin
        cand_d = w_cur_cand;
        cnt_d  = w_cur_cnt;
        if (!(w_up || w_down)) begin
            cand_d = w_cur_lvl;
            cnt_d  = '0;
        end else if (w_new_lvl != w_cur_cand) begin
            cand_d = w_new_lvl;
            cnt_d  = c_CNT_W'(1);
        end else begin
            cnt_d  = w_cur_cnt + c_CNT_W'(1);
        end
        w_commit = (cnt_d == c_STABLE);
        if (w_commit) begin
            cnt_d = '0;
        end
    end

    // Primed mask including the channel currently being primed
    always_comb begin
        primed_d           = primed_q;
        primed_d[ch_idx_q] = 1'b1;
    end

    // Visit sequencer: latch the value, then classify/commit the channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ch_idx_q  <= '0;
            v_q       <= '0;
            primed_q  <= '0;
            changed_q <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                lvl_q[i]  <= '0;
                cand_q[i] <= '0;
                cnt_q[i]  <= '0;
`ifdef ADC_LVL_FILTER_EN
                filt_q[i] <= '0;
`endif
            end
        end else begin
            changed_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (w_tick) begin
                        state_q <= S_FILT;
                    end
                end
                S_FILT: begin
                    v_q <= v_d;
`ifdef ADC_LVL_FILTER_EN
                    filt_q[ch_idx_q] <= v_d;
`endif
                    state_q <= S_CLASS;
                end
                S_CLASS: begin
                    if (!primed_q[ch_idx_q]) begin
                        // First visit adopts the raw bin silently
                        lvl_q[ch_idx_q]  <= w_raw_lvl;
                        cand_q[ch_idx_q] <= w_raw_lvl;
                        cnt_q[ch_idx_q]  <= '0;
                        primed_q         <= primed_d;
                        ready_q          <= &primed_d;
                    end else begin
                        cand_q[ch_idx_q] <= cand_d;
                        cnt_q[ch_idx_q]  <= cnt_d;
                        if (w_commit) begin
                            lvl_q[ch_idx_q]     <= cand_d;
                            changed_q[ch_idx_q] <= 1'b1;
                        end
                    end
                    ch_idx_q <= next_ch(ch_idx_q);
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lvl0    = lvl_q[0];
    assign lvl1    = lvl_q[1];
    assign lvl2    = lvl_q[2];
    assign lvl3    = lvl_q[3];
    assign lvl4    = lvl_q[4];
    assign lvl5    = lvl_q[5];
    assign changed = changed_q;
    assign ready   = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_level_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_level_classifier
// Brief    : Self-checking bench for adc_level_classifier. Stimulus drives
//            each channel just before its scheduled visit, updates a
//            behavioural model and queues expected change events; a monitor
//            pops and compares on every changed pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_level_classifier;

    localparam int SCAN_DIV     = 4;
    localparam int LEVEL_BITS   = 3;
    localparam int HYST         = 32;
    localparam int STABLE_SCANS = 3;
    localparam int FILT_SHIFT   = 2;
    localparam int BIN          = 4096 >> LEVEL_BITS;
    localparam int MAXL         = (1 << LEVEL_BITS) - 1;

    logic                  clk     = 1'b0;
    logic                  reset_n = 1'b0;
    logic [11:0]           ch_drv [6];
    logic [LEVEL_BITS-1:0] lvl    [6];
    logic [5:0]            changed;
    logic                  ready;

    adc_level_classifier #(
        .SCAN_DIV     (SCAN_DIV),
        .LEVEL_BITS   (LEVEL_BITS),
        .HYST         (HYST),
        .STABLE_SCANS (STABLE_SCANS),
        .FILT_SHIFT   (FILT_SHIFT)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ch0     (ch_drv[0]),
        .ch1     (ch_drv[1]),
        .ch2     (ch_drv[2]),
        .ch3     (ch_drv[3]),
        .ch4     (ch_drv[4]),
        .ch5     (ch_drv[5]),
        .lvl0    (lvl[0]),
        .lvl1    (lvl[1]),
        .lvl2    (lvl[2]),
        .lvl3    (lvl[3]),
        .lvl4    (lvl[4]),
        .lvl5    (lvl[5]),
        .changed (changed),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int lvl;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state per channel
    int m_primed [6];
    int m_filt   [6];
    int m_lvl    [6];
    int m_cand   [6];
    int m_cnt    [6];

    int tgt [6];
    int vis_idx   = 0;
    bit arm_reset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int clamp12(input int v);
        if (v < 0)    return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

`ifdef ADC_LVL_FILTER_EN
    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_primed[i] = 0;
            m_filt[i]   = 0;
            m_lvl[i]    = 0;
            m_cand[i]   = 0;
            m_cnt[i]    = 0;
        end
    endtask

    // Next state of channel c for sample s, as described by the level rules
    task automatic model_eval(input int c, input int s,
                              output int nf, output int nl, output int nc,
                              output int nn, output bit cm);
        int  v;
        int  prop;
        bit  crossed;
        cm = 1'b0;
        if (m_primed[c] == 0) begin
            nf = s;
            nl = s / BIN;
            nc = nl;
            nn = 0;
            return;
        end
`ifdef ADC_LVL_FILTER_EN
        if ((s - m_filt[c]) > -(1 << FILT_SHIFT) && (s - m_filt[c]) < (1 << FILT_SHIFT))
            v = s;
        else
            v = m_filt[c] + floor_div(s - m_filt[c], 1 << FILT_SHIFT);
`else
        v = s;
`endif
        nf = v;
        nl = m_lvl[c];
        crossed = (m_lvl[c] < MAXL && v >= (m_lvl[c] + 1) * BIN + HYST) ||
                  (m_lvl[c] > 0    && v <  m_lvl[c] * BIN - HYST);
        prop = crossed ? (v / BIN) : m_lvl[c];
        if (prop == m_lvl[c]) begin
            nc = m_lvl[c];
            nn = 0;
        end else if (prop != m_cand[c]) begin
            nc = prop;
            nn = 1;
        end else begin
            nc = m_cand[c];
            nn = m_cnt[c] + 1;
        end
        if (nn == STABLE_SCANS) begin
            nl = nc;
            nn = 0;
            cm = 1'b1;
        end
    endtask

    task automatic check_state();
        int all_primed;
        all_primed = 1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lvl%0d", i), 32'(lvl[i]), 32'(m_lvl[i]));
            if (m_primed[i] == 0) all_primed = 0;
        end
        chk("ready", 32'(ready), 32'(all_primed));
    endtask

    // One scheduled visit of channel vis_idx%6 using tgt[]; entered just
    // after the posedge two clocks before that visit's sampling cycle
    task automatic do_visit();
        int c, nf, nl, nc, nn;
        bit cm;
        c = vis_idx % 6;
        @(negedge clk);
        check_state();
        ch_drv[c] = 12'(tgt[c]);
        model_eval(c, tgt[c], nf, nl, nc, nn, cm);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (arm_reset && cm) begin
            reset_n   = 1'b0;
            arm_reset = 1'b0;
            #1;
            model_reset();
            check_state();
            chk("changed_at_reset", 32'(changed), 32'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("changed_in_reset", 32'(changed), 32'd0);
            ch_drv[c] = 12'($urandom);
            reset_n = 1'b1;
            vis_idx = 0;
            repeat (2) @(posedge clk);
            return;
        end
        m_primed[c] = 1;
        m_filt[c]   = nf;
        m_lvl[c]    = nl;
        m_cand[c]   = nc;
        m_cnt[c]    = nn;
        if (cm) begin
            evt_t e;
            e.chan = c;
            e.lvl  = nl;
            exp_q.push_back(e);
        end
        // Inputs between visits must be ignored
        ch_drv[c] = 12'($urandom);
        vis_idx++;
        @(posedge clk);
    endtask

    task automatic run_visits(input int n);
        repeat (n) do_visit();
    endtask

    task automatic mutate(input int c);
        int r;
        int off;
        r = $urandom_range(0, 9);
        if (r >= 4 && r <= 5) begin
            tgt[c] = clamp12(tgt[c] + $urandom_range(0, 80) - 40);
        end else if (r >= 6 && r <= 7) begin
            tgt[c] = $urandom_range(0, 4095);
        end else if (r == 8) begin
            case ($urandom_range(0, 3))
                0:       off = -HYST - 1;
                1:       off = -HYST;
                2:       off = HYST - 1;
                default: off = HYST;
            endcase
            tgt[c] = clamp12($urandom_range(1, MAXL) * BIN + off);
        end else if (r == 9) begin
            tgt[c] = ($urandom_range(0, 1) == 1) ? 4095 : 0;
        end
    endtask

    // Scoreboard monitor: every changed pulse must match the next event
    always @(negedge clk) begin : mon
        evt_t e;
        if (reset_n === 1'b1 && changed !== 6'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL changed_unexpected: got %b, required 000000", changed);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("changed_mask_ch%0d", e.chan), 32'(changed), 32'(1) << e.chan);
                chk($sformatf("changed_lvl_ch%0d", e.chan), 32'(lvl[e.chan]), 32'(e.lvl));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 6; i++) begin
            ch_drv[i] = 12'd0;
            tgt[i]    = 1000;
        end
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_state();
        chk("changed_reset", 32'(changed), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // All channels at 1000: prime to level 1, no pulses
        run_visits(6);

        // Small moves below the upper hysteresis edge
        tgt[0] = 1030;
        run_visits(6);
        tgt[0] = 1050;
        run_visits(12);

        // Clear crossing commits on the third visit; small return holds
        tgt[0] = 1100;
        run_visits(18);
        tgt[0] = 1010;
        run_visits(18);

        // Alternating candidate never persists; then full-scale extremes
        for (int r = 0; r < 8; r++) begin
            tgt[3] = (r % 2 == 1) ? 3000 : 2000;
            run_visits(6);
        end
        tgt[3] = 4095;
        run_visits(18);
        tgt[3] = 0;
        run_visits(18);

        // Reset asserted inside a committing visit, then re-prime
        tgt[2]    = 3500;
        arm_reset = 1'b1;
        run_visits(36);
        arm_reset = 1'b0;

        // Full-scale step on ch1 (long run lets a filtered build settle)
        tgt[1] = 0;
        run_visits(12);
        tgt[1] = 4095;
        run_visits(180);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            mutate(vis_idx % 6);
            do_visit();
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_state();
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
